bit_index_sequencer: RTL and testbench

- Takes a WIDTH-bit word through a valid/ready input handshake.
- Streams out the indices of all set bits, lowest index first, two indices per output beat, through a valid/ready output handshake.
- Contains one instance of a generalized first-two-set-bit finder and sequences it over the word, clearing reported bits after each beat.
- Sits between a flag/request producer and any consumer that services set positions in order, such as an interrupt or request dispatcher.

---
 rtl/bis_pkg.sv | 18 +
 rtl/pair_index_finder.sv | 38 +++
 rtl/bit_index_sequencer.sv | 105 ++++++++++
 tb/tb_bit_index_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bis_pkg.sv
// rtl/bis_pkg.sv - shared state type and mask helpers for bit_index_sequencer
package bis_pkg;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  // Callers zero-extend their mask to this width before calling the helper.
  localparam int MAX_WIDTH = 64;

  function automatic logic popcount_le2(input logic [MAX_WIDTH-1:0] m);
    int c;
    c = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      c += int'(m[i]);
    end
    return (c <= 2);
  endfunction

endpackage

// File: rtl/pair_index_finder.sv
// rtl/pair_index_finder.sv - combinational finder for the two lowest set bits of a mask
module pair_index_finder #(
  parameter int WIDTH = 16,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDXW-1:0]  idx0,
  output logic             v0,
  output logic [IDXW-1:0]  idx1,
  output logic             v1,
  output logic [WIDTH-1:0] clr_mask
);

  always_comb begin
    idx0 = '0;
    v0   = 1'b0;
    idx1 = '0;
    v1   = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (mask[i]) begin
        if (!v0) begin
          v0   = 1'b1;
          idx0 = IDXW'(i);
        end else if (!v1) begin
          v1   = 1'b1;
          idx1 = IDXW'(i);
        end
      end
    end
  end

  always_comb begin
    clr_mask = mask;
    if (v0) clr_mask[idx0] = 1'b0;
    if (v1) clr_mask[idx1] = 1'b0;
  end

endmodule

// File: rtl/bit_index_sequencer.sv
// rtl/bit_index_sequencer.sv - streams set-bit indices of a word, two per beat, lowest first
module bit_index_sequencer
  import bis_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx0,
  output logic [IDXW-1:0]  out_idx1,
  output logic             out_v0,
  output logic             out_v1,
  output logic             out_last,
  output logic [IDXW-1:0]  out_beat
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_mask;
  logic [IDXW-1:0]  r_beat;

  logic [IDXW-1:0]  w_idx0;
  logic [IDXW-1:0]  w_idx1;
  logic             w_v0;
  logic             w_v1;
  logic [WIDTH-1:0] w_clr_mask;
  logic             w_last;
  logic             w_in_fire;
  logic             w_out_fire;

  pair_index_finder #(.WIDTH(WIDTH)) u_finder (
    .mask     (r_mask),
    .idx0     (w_idx0),
    .v0       (w_v0),
    .idx1     (w_idx1),
    .v1       (w_v1),
    .clr_mask (w_clr_mask)
  );

  assign w_last     = popcount_le2(MAX_WIDTH'(r_mask));
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_next = EMIT;
      EMIT: if (out_ready && w_last) w_state_next = in_valid ? EMIT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are gated by rst as well so nothing leaks while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx0  = '0;
    out_idx1  = '0;
    out_v0    = 1'b0;
    out_v1    = 1'b0;
    out_last  = 1'b0;
    out_beat  = '0;
    if (!rst) begin
      case (r_state)
        IDLE: in_ready = 1'b1;
        EMIT: begin
          out_valid = 1'b1;
          out_idx0  = w_idx0;
          out_idx1  = w_idx1;
          out_v0    = w_v0;
          out_v1    = w_v1;
          out_last  = w_last;
          out_beat  = r_beat;
          in_ready  = out_ready && w_last;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
      r_beat <= '0;
    end else if (w_in_fire) begin
      r_mask <= in_word;
      r_beat <= '0;
    end else if (w_out_fire && !w_last) begin
      r_mask <= w_clr_mask;
      r_beat <= r_beat + IDXW'(1);
    end
  end

endmodule

// File: tb/tb_bit_index_sequencer.sv
// tb/tb_bit_index_sequencer.sv - self-checking bench for bit_index_sequencer
module tb_bit_index_sequencer;

  typedef struct {
    int i0;
    int i1;
    int v0;
    int v1;
    int last;
    int beat;
    int cyc;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx0;
  logic [3:0]  out_idx1;
  logic        out_v0;
  logic        out_v1;
  logic        out_last;
  logic [3:0]  out_beat;

  int n_checks = 0;
  int n_fails  = 0;
  int cycle    = 0;

  beat_t mq[$];
  beat_t dlog[$];

  bit_index_sequencer #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx0  (out_idx0),
    .out_idx1  (out_idx1),
    .out_v0    (out_v0),
    .out_v1    (out_v1),
    .out_last  (out_last),
    .out_beat  (out_beat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Model: a word becomes the list of its set positions, chopped into pairs.
  task automatic push_word(input logic [15:0] w);
    int idx[$];
    int nb;
    beat_t b;
    for (int i = 0; i < 16; i++) if (w[i]) idx.push_back(i);
    nb = (idx.size() == 0) ? 1 : (idx.size() + 1) / 2;
    for (int k = 0; k < nb; k++) begin
      b.v0   = (2 * k < idx.size()) ? 1 : 0;
      b.i0   = b.v0 ? idx[2 * k] : 0;
      b.v1   = (2 * k + 1 < idx.size()) ? 1 : 0;
      b.i1   = b.v1 ? idx[2 * k + 1] : 0;
      b.last = (k == nb - 1) ? 1 : 0;
      b.beat = k;
      b.cyc  = 0;
      mq.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    int exp_ov;
    int exp_ir;
    beat_t e;
    beat_t d;
    exp_ov = (!rst && mq.size() != 0) ? 1 : 0;
    exp_ir = (!rst && (mq.size() == 0 || (out_ready && mq.size() == 1))) ? 1 : 0;
    chk("in_ready", int'(in_ready), exp_ir);
    chk("out_valid", int'(out_valid), exp_ov);
    if (exp_ov != 0) e = mq[0];
    else e = '{0, 0, 0, 0, 0, 0, 0};
    chk("out_idx0", int'(out_idx0), e.i0);
    chk("out_idx1", int'(out_idx1), e.i1);
    chk("out_v0", int'(out_v0), e.v0);
    chk("out_v1", int'(out_v1), e.v1);
    chk("out_last", int'(out_last), e.last);
    chk("out_beat", int'(out_beat), e.beat);
    if (rst) begin
      mq.delete();
    end else begin
      if (exp_ov != 0 && out_ready) begin
        d = '{int'(out_idx0), int'(out_idx1), int'(out_v0), int'(out_v1),
              int'(out_last), int'(out_beat), cycle};
        dlog.push_back(d);
        void'(mq.pop_front());
      end
      if (in_valid && exp_ir != 0) push_word(in_word);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input bit hold);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_word  = w;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    chk("send_timeout", int'(ok), 1);
    if (!hold) begin
      in_valid = 1'b0;
      in_word  = 16'($urandom);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && mq.size() != 0; n++) cyc(1);
    chk("drain_timeout", mq.size(), 0);
  endtask

  task automatic check_log(input int k, input int i0, input int i1, input int v0,
                           input int v1, input int last, input int beat);
    if (k >= dlog.size()) begin
      chk("log_missing_beat", dlog.size(), k + 1);
    end else begin
      chk("lit_idx0", dlog[k].i0, i0);
      chk("lit_idx1", dlog[k].i1, i1);
      chk("lit_v0", dlog[k].v0, v0);
      chk("lit_v1", dlog[k].v1, v1);
      chk("lit_last", dlog[k].last, last);
      chk("lit_beat", dlog[k].beat, beat);
    end
  endtask

  initial begin
    int base;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_word   = 16'h1234;
    out_ready = 1'b1;

    // Reset held two cycles with a word offered
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    cyc(1);

    // Two-bit word
    base = dlog.size();
    send(16'h000C, 0);
    drain();
    chk("w000c_beats", dlog.size() - base, 1);
    check_log(base, 2, 3, 1, 1, 1, 0);

    // Odd popcount with backpressure
    base = dlog.size();
    out_ready = 1'b0;
    send(16'h0007, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_idx0", int'(out_idx0), 0);
      chk("bp_idx1", int'(out_idx1), 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();
    chk("w0007_beats", dlog.size() - base, 2);
    check_log(base, 0, 1, 1, 1, 0, 0);
    check_log(base + 1, 2, 0, 1, 0, 1, 1);

    // Zero word
    base = dlog.size();
    send(16'h0000, 0);
    drain();
    chk("w0000_beats", dlog.size() - base, 1);
    check_log(base, 0, 0, 0, 0, 1, 0);

    // Full word
    base = dlog.size();
    send(16'hFFFF, 0);
    drain();
    chk("wffff_beats", dlog.size() - base, 8);
    for (int k = 0; k < 8; k++) check_log(base + k, 2 * k, 2 * k + 1, 1, 1, (k == 7) ? 1 : 0, k);

    // Back-to-back words, no bubble
    cyc(2);
    base = dlog.size();
    send(16'h8001, 1);
    send(16'h0030, 0);
    drain();
    chk("b2b_beats", dlog.size() - base, 2);
    check_log(base, 0, 15, 1, 1, 1, 0);
    check_log(base + 1, 4, 5, 1, 1, 1, 0);
    if (dlog.size() >= base + 2) chk("b2b_gap", dlog[base + 1].cyc - dlog[base].cyc, 1);

    // Reset in the middle of a word
    cyc(2);
    base = dlog.size();
    send(16'h00FF, 0);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    chk("midrst_beats", dlog.size() - base, 1);
    check_log(base, 0, 1, 1, 1, 0, 0);
    base = dlog.size();
    send(16'h0100, 0);
    drain();
    chk("w0100_beats", dlog.size() - base, 1);
    check_log(base, 8, 0, 1, 0, 1, 0);

    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
